priority_encoder: RTL and testbench

PRIORITY_ENCODER -- requirements
Module: priority_encoder

---
 rtl/priority_encoder.sv | 86 ++++++++
 tb/tb_priority_encoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - 8-to-3 priority encoder with enable, group select, cascade enable out and optional output register
module priority_encoder #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic ei,
    input  logic p0,
    input  logic p1,
    input  logic p2,
    input  logic p3,
    input  logic p4,
    input  logic p5,
    input  logic p6,
    input  logic p7,
    output logic z1,
    output logic z2,
    output logic z4,
    output logic gs,
    output logic eo
);

    logic [7:0] req;
    logic [2:0] enc_idx;
    logic       enc_any;
    logic [2:0] nxt_idx;
    logic       nxt_gs;
    logic       nxt_eo;

    assign req = {p7, p6, p5, p4, p3, p2, p1, p0};

    // Highest-numbered active request wins; the casez order masks every lower request
    always_comb begin
        enc_idx = 3'd0;
        enc_any = 1'b1;
        casez (req)
            8'b1???_????: enc_idx = 3'd7;
            8'b01??_????: enc_idx = 3'd6;
            8'b001?_????: enc_idx = 3'd5;
            8'b0001_????: enc_idx = 3'd4;
            8'b0000_1???: enc_idx = 3'd3;
            8'b0000_01??: enc_idx = 3'd2;
            8'b0000_001?: enc_idx = 3'd1;
            8'b0000_0001: enc_idx = 3'd0;
            default:      enc_any = 1'b0;
        endcase
    end

    // Disabled encoder drives all zeros; gs and eo are mutually exclusive by construction
    always_comb begin
        nxt_idx = (ei && enc_any) ? enc_idx : 3'd0;
        nxt_gs  = ei & enc_any;
        nxt_eo  = ei & ~enc_any;
    end

    generate
        if (OUT_REG) begin : g_reg
            // Capture the encoding each rising edge; reset clears the result without waiting for clk
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    z1 <= 1'b0;
                    z2 <= 1'b0;
                    z4 <= 1'b0;
                    gs <= 1'b0;
                    eo <= 1'b0;
                end else begin
                    z1 <= nxt_idx[0];
                    z2 <= nxt_idx[1];
                    z4 <= nxt_idx[2];
                    gs <= nxt_gs;
                    eo <= nxt_eo;
                end
            end
        end else begin : g_comb
            // Clock and reset play no part in the combinational build
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign z1 = nxt_idx[0];
            assign z2 = nxt_idx[1];
            assign z4 = nxt_idx[2];
            assign gs = nxt_gs;
            assign eo = nxt_eo;
        end
    endgenerate

endmodule

// File: tb/tb_priority_encoder.sv
// tb/tb_priority_encoder.sv - self-checking bench for registered and combinational priority_encoder builds
module tb_priority_encoder;

    logic       clk;
    logic       rst;
    logic       ei;
    logic [7:0] p;

    logic r_z1, r_z2, r_z4, r_gs, r_eo;
    logic c_z1, c_z2, c_z4, c_gs, c_eo;
    logic [4:0] out_r;
    logic [4:0] out_c;

    int n_cmp;
    int n_bad;

    typedef struct {
        string      name;
        logic       ei;
        logic [7:0] p;
        logic [4:0] exp;   // {z4,z2,z1,gs,eo}
    } vec_t;

    vec_t tbl[8];

    assign out_r = {r_z4, r_z2, r_z1, r_gs, r_eo};
    assign out_c = {c_z4, c_z2, c_z1, c_gs, c_eo};

    priority_encoder #(.OUT_REG(1'b1)) u_reg (
        .clk(clk), .rst(rst), .ei(ei),
        .p0(p[0]), .p1(p[1]), .p2(p[2]), .p3(p[3]),
        .p4(p[4]), .p5(p[5]), .p6(p[6]), .p7(p[7]),
        .z1(r_z1), .z2(r_z2), .z4(r_z4), .gs(r_gs), .eo(r_eo)
    );

    priority_encoder #(.OUT_REG(1'b0)) u_comb (
        .clk(clk), .rst(rst), .ei(ei),
        .p0(p[0]), .p1(p[1]), .p2(p[2]), .p3(p[3]),
        .p4(p[4]), .p5(p[5]), .p6(p[6]), .p7(p[7]),
        .z1(c_z1), .z2(c_z2), .z4(c_z4), .gs(c_gs), .eo(c_eo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: index of highest set bit from ceil-log2 arithmetic
    function automatic logic [4:0] model(input logic e, input logic [7:0] v);
        int idx;
        if (!e) return 5'b00000;
        if (v == 8'd0) return 5'b00001;
        idx = $clog2(int'(v) + 1) - 1;
        return {idx[2:0], 2'b10};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {z4,z2,z1,gs,eo}=%b expected %b", name, act, exp);
        end
    endtask

    // Drive after a falling edge, check the comb build at once and the registered build after the next rising edge
    task automatic apply(input string name, input logic e, input logic [7:0] v, input logic [4:0] exp);
        @(negedge clk);
        ei = e;
        p  = v;
        #1;
        check({name, "_comb"}, out_c, exp);
        @(posedge clk);
        #1;
        check({name, "_reg"}, out_r, exp);
        check({name, "_gs_eo_excl"}, {4'b0000, r_gs & r_eo}, 5'b00000);
    endtask

    initial begin
        logic [7:0] rv;
        logic       re;
        n_cmp = 0;
        n_bad = 0;

        tbl[0] = '{"p6_p3_p0",   1'b1, 8'b0100_1001, 5'b110_1_0};
        tbl[1] = '{"none_en",    1'b1, 8'b0000_0000, 5'b000_0_1};
        tbl[2] = '{"p0_only",    1'b1, 8'b0000_0001, 5'b000_1_0};
        tbl[3] = '{"dis_all1",   1'b0, 8'b1111_1111, 5'b000_0_0};
        tbl[4] = '{"p5_p2",      1'b1, 8'b0010_0100, 5'b101_1_0};
        tbl[5] = '{"all1_en",    1'b1, 8'b1111_1111, 5'b111_1_0};
        tbl[6] = '{"dis_none",   1'b0, 8'b0000_0000, 5'b000_0_0};
        tbl[7] = '{"p1_only",    1'b1, 8'b0000_0010, 5'b001_1_0};

        // Reset asserted with p7 active: registered outputs clear before any clock edge
        rst = 1'b1;
        ei  = 1'b1;
        p   = 8'b1000_0000;
        #1 rst = 1'b0;
        #1;
        check("reset_async_reg", out_r, 5'b00000);
        check("reset_ignored_comb", out_c, 5'b111_1_0);
        @(posedge clk);
        #1;
        check("reset_hold_reg", out_r, 5'b00000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_load", out_r, 5'b111_1_0);

        for (int i = 0; i < 8; i++)
            apply(tbl[i].name, tbl[i].ei, tbl[i].p, tbl[i].exp);

        // Walking one, one request per cycle
        for (int i = 0; i < 8; i++)
            apply($sformatf("walk_p%0d", i), 1'b1, 8'd1 << i, {i[2:0], 2'b10});

        // Inputs changed between edges must not reach the registered outputs early
        apply("hold_a", 1'b1, 8'b0001_0000, 5'b100_1_0);
        @(negedge clk);
        p = 8'b0000_0100;
        #1;
        check("between_edges_reg", out_r, 5'b100_1_0);
        check("between_edges_comb", out_c, 5'b010_1_0);
        @(posedge clk);
        #1;
        check("next_edge_reg", out_r, 5'b010_1_0);

        // Mid-operation reset discards the held result immediately
        apply("pre_rst", 1'b1, 8'b0100_0000, 5'b110_1_0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_clear", out_r, 5'b00000);
        @(posedge clk);
        #1;
        check("mid_rst_hold", out_r, 5'b00000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_reload", out_r, 5'b110_1_0);

        // Random vectors with the encoder enabled
        for (int i = 0; i < 24; i++) begin
            rv = 8'($urandom);
            apply($sformatf("rand_en_%0d", i), 1'b1, rv, model(1'b1, rv));
        end

        // Random vectors with random enable
        for (int i = 0; i < 12; i++) begin
            rv = 8'($urandom);
            re = 1'($urandom_range(0, 1));
            apply($sformatf("rand_ei_%0d", i), re, rv, model(re, rv));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
